pc_control: RTL and testbench

PC sequencing controller that sits directly upstream of the fetch stage. It drives fetch's `pc_select`, `pc_place` and `index` every cycle. It owns these sequences:

- the reset-vector boot sequence;
- exception and interrupt vectoring, each a two-step "go to vector, then load the address stored there";
- pipeline-drain timing before an interrupt;
- priority arbitration between redirects (ret, call/jump), stalls and sequential fetch.

---
 rtl/pc_control_if.sv | 34 +++
 rtl/pc_control.sv | 163 ++++++++++++++++
 tb/tb_pc_control.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_control_if.sv
// Request/response bundle between the pipeline and the PC sequencing controller.
// The pipeline side (master) raises hazard, redirect, exception and interrupt
// requests; the controller (slave) answers with the fetch-control word every
// cycle. There is no valid/ready pair: every field is sampled or driven on
// every clock, and the level of each request input is the request itself.
interface pc_control_if;
  logic       stall;
  logic       inst_is_32;
  logic       ret_taken;
  logic       call_taken;
  logic       exc_req;
  logic [1:0] exc_code;
  logic       int_req;
  logic [2:0] int_index;

  logic [1:0] pc_select;
  logic [3:0] pc_place;
  logic [2:0] index;
  logic       flush_if;
  logic       int_ack;
  logic       busy;

  modport master (
    output stall, inst_is_32, ret_taken, call_taken,
    output exc_req, exc_code, int_req, int_index,
    input  pc_select, pc_place, index, flush_if, int_ack, busy
  );

  modport slave (
    input  stall, inst_is_32, ret_taken, call_taken,
    input  exc_req, exc_code, int_req, int_index,
    output pc_select, pc_place, index, flush_if, int_ack, busy
  );
endinterface

// File: rtl/pc_control.sv
// PC sequencing controller upstream of fetch. Runs the reset-vector boot,
// exception and interrupt vectoring (vector, then load the stored address),
// the pre-interrupt drain window, and the RUN-state priority arbitration of
// exception > ret > call/jump > interrupt > stall > sequential.
module pc_control #(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  pc_control_if.slave      bus,
  output logic [2:0]       o_dbg_state
);

  typedef enum logic [2:0] {
    RST_VEC   = 3'd0,
    RST_LOAD  = 3'd1,
    RUN       = 3'd2,
    INT_DRAIN = 3'd3,
    INT_VEC   = 3'd4,
    EXC_VEC   = 3'd5,
    VEC_LOAD  = 3'd6
  } state_t;

  // pc_place codes understood by fetch
  localparam logic [3:0] PLACE_NONE   = 4'b0000;
  localparam logic [3:0] PLACE_ZERO   = 4'b0001;
  localparam logic [3:0] PLACE_EXC0   = 4'b0010;
  localparam logic [3:0] PLACE_EXC1   = 4'b0011;
  localparam logic [3:0] PLACE_EXC2   = 4'b0100;
  localparam logic [3:0] PLACE_IVT    = 4'b0101;
  localparam logic [3:0] PLACE_RET    = 4'b0110;
  localparam logic [3:0] PLACE_CALL   = 4'b0111;
  localparam logic [3:0] PLACE_MEMLD  = 4'b1000;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_P1   = 2'b01;
  localparam logic [1:0] SEL_P2   = 2'b10;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_drain;
  logic [2:0] r_index;
  logic       r_int_ack;
  logic [1:0] r_exc_code;

  logic [3:0] w_pc_place;
  logic [1:0] w_pc_select;
  logic       w_flush;
  logic       w_take_int;
  logic       w_take_exc;

  // State register; any reset lands in the boot vector immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= RST_VEC;
    else       r_state <= w_next_state;
  end

  // Interrupt bookkeeping: index and drain count latched on detect, the
  // acknowledge is high only in the cycle right after the detect cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_index   <= '0;
      r_drain   <= '0;
      r_int_ack <= 1'b0;
    end else begin
      r_int_ack <= w_take_int;
      if (w_take_int) begin
        r_index <= bus.int_index;
        r_drain <= DRAIN_INIT;
      end else if (r_state == INT_DRAIN) begin
        r_drain <= r_drain - 4'd1;
      end
    end
  end

  // Exception cause is captured on detect so EXC_VEC ignores later input changes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)           r_exc_code <= '0;
    else if (w_take_exc) r_exc_code <= bus.exc_code;
  end

  // Next-state and fetch-control decode; outside RUN the outputs follow state only.
  always_comb begin
    w_next_state = r_state;
    w_pc_place   = PLACE_NONE;
    w_pc_select  = SEL_HOLD;
    w_flush      = 1'b0;
    w_take_int   = 1'b0;
    w_take_exc   = 1'b0;
    case (r_state)
      RST_VEC: begin
        w_pc_place   = PLACE_ZERO;
        w_flush      = 1'b1;
        w_next_state = RST_LOAD;
      end
      RST_LOAD: begin
        w_pc_place   = PLACE_MEMLD;
        w_flush      = 1'b1;
        w_next_state = RUN;
      end
      RUN: begin
        if (bus.exc_req) begin
          w_flush      = 1'b1;
          w_take_exc   = 1'b1;
          w_next_state = EXC_VEC;
        end else if (bus.ret_taken) begin
          w_pc_place = PLACE_RET;
          w_flush    = 1'b1;
        end else if (bus.call_taken) begin
          w_pc_place = PLACE_CALL;
          w_flush    = 1'b1;
        end else if (bus.int_req) begin
          w_flush      = 1'b1;
          w_take_int   = 1'b1;
          w_next_state = (DRAIN_INIT == 4'd0) ? INT_VEC : INT_DRAIN;
        end else if (bus.stall) begin
          w_pc_select = SEL_HOLD;
        end else begin
          w_pc_select = bus.inst_is_32 ? SEL_P2 : SEL_P1;
        end
      end
      INT_DRAIN: begin
        w_flush = 1'b1;
        // counter is never 0 here, the <= guards against a stray value
        if (r_drain <= 4'd1) w_next_state = INT_VEC;
      end
      INT_VEC: begin
        w_pc_place   = PLACE_IVT;
        w_flush      = 1'b1;
        w_next_state = VEC_LOAD;
      end
      EXC_VEC: begin
        w_flush      = 1'b1;
        w_next_state = VEC_LOAD;
        case (r_exc_code)
          2'b00:   w_pc_place = PLACE_EXC0;
          2'b01:   w_pc_place = PLACE_EXC1;
          default: w_pc_place = PLACE_EXC2;
        endcase
      end
      VEC_LOAD: begin
        w_pc_place   = PLACE_MEMLD;
        w_next_state = RUN;
      end
      default: begin
        w_pc_place   = PLACE_ZERO;
        w_flush      = 1'b1;
        w_next_state = RST_VEC;
      end
    endcase
  end

  assign bus.pc_place  = w_pc_place;
  assign bus.pc_select = w_pc_select;
  assign bus.flush_if  = w_flush;
  assign bus.index     = r_index;
  assign bus.int_ack   = r_int_ack;
  assign bus.busy      = (r_state != RUN);
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_pc_control.sv
// Bench for pc_control. The reference model is a queue of the fetch-control
// words owed after each detected event (boot, exception, interrupt); when that
// queue is empty the controller is running and the word follows from the
// RUN priority list applied to the current requests.
module tb_pc_control;
  localparam int DRAIN = 2;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] place;
    logic [2:0] idx;
    logic       flush;
    logic       ack;
    logic       busy;
  } out_t;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;
  int         total;
  int         bad;

  pc_control_if bus();

  pc_control #(.DRAIN_CYCLES(DRAIN)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  out_t       pend_q[$];
  logic [2:0] m_index;
  logic       m_ack;

  function automatic out_t mk(logic [1:0] sel, logic [3:0] place, logic flush);
    out_t o;
    o = '0;
    o.sel = sel; o.place = place; o.flush = flush;
    return o;
  endfunction

  function automatic void model_reset();
    pend_q.delete();
    pend_q.push_back(mk(2'd0, 4'd1, 1'b1)); // PC <- 0
    pend_q.push_back(mk(2'd0, 4'd8, 1'b1)); // PC <- mem[0]
    m_index = '0;
    m_ack   = 1'b0;
  endfunction

  function automatic out_t expect_now();
    out_t e;
    e = '0;
    e.idx = m_index;
    e.ack = m_ack;
    if (pend_q.size() != 0) begin
      e.sel   = pend_q[0].sel;
      e.place = pend_q[0].place;
      e.flush = pend_q[0].flush;
      e.busy  = 1'b1;
    end else if (bus.exc_req)    e.flush = 1'b1;
    else if (bus.ret_taken)      begin e.place = 4'd6; e.flush = 1'b1; end
    else if (bus.call_taken)     begin e.place = 4'd7; e.flush = 1'b1; end
    else if (bus.int_req)        e.flush = 1'b1;
    else if (bus.stall)          e.sel = 2'd0;
    else                         e.sel = bus.inst_is_32 ? 2'd2 : 2'd1;
    return e;
  endfunction

  // Applied once per clock edge, using the requests present at that edge.
  function automatic void model_commit();
    int code;
    m_ack = 1'b0;
    if (pend_q.size() != 0) begin
      void'(pend_q.pop_front());
    end else if (bus.exc_req) begin
      code = (bus.exc_code == 2'd3) ? 2 : int'(bus.exc_code);
      pend_q.push_back(mk(2'd0, 4'(2 + code), 1'b1));
      pend_q.push_back(mk(2'd0, 4'd8, 1'b0));
    end else if (bus.ret_taken || bus.call_taken) begin
      // redirect handled inside the cycle
    end else if (bus.int_req) begin
      m_index = bus.int_index;
      m_ack   = 1'b1;
      for (int i = 0; i < DRAIN; i++) pend_q.push_back(mk(2'd0, 4'd0, 1'b1));
      pend_q.push_back(mk(2'd0, 4'd5, 1'b1));
      pend_q.push_back(mk(2'd0, 4'd8, 1'b0));
    end
  endfunction

  function automatic out_t observed();
    out_t o;
    o.sel = bus.pc_select; o.place = bus.pc_place; o.idx = bus.index;
    o.flush = bus.flush_if; o.ack = bus.int_ack; o.busy = bus.busy;
    return o;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(logic st, logic i32, logic rt, logic ct, logic ex,
                       logic [1:0] ec, logic ir, logic [2:0] ii);
    bus.stall = st; bus.inst_is_32 = i32; bus.ret_taken = rt; bus.call_taken = ct;
    bus.exc_req = ex; bus.exc_code = ec; bus.int_req = ir; bus.int_index = ii;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    out_t e, g;
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 3'd7);
    repeat (2) @(posedge clk);
    #1;
    e = mk(2'd0, 4'd1, 1'b1);
    e.busy = 1'b1;
    g = observed();
    total++;
    if (g !== e) begin
      $display("FAIL reset_state got=%h exp=%h", g, e); bad++;
    end
    drive_idle();
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_boot();
    out_t e, g;
    for (int c = 0; c < 4; c++) begin
      drive_idle();
      @(negedge clk);
      e = expect_now(); g = observed();
      total++;
      if (g !== e) begin
        $display("FAIL boot cyc=%0d got=%h exp=%h", c, g, e); bad++;
      end
      model_commit();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_seq_stall();
    out_t e, g;
    logic [1:0] sel_exp [4];
    sel_exp[0] = 2'd2; sel_exp[1] = 2'd0; sel_exp[2] = 2'd0; sel_exp[3] = 2'd1;
    for (int c = 0; c < 4; c++) begin
      drive((c == 1 || c == 2), (c == 0), 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0);
      @(negedge clk);
      e = expect_now(); g = observed();
      total++;
      if (g !== e || g.sel !== sel_exp[c] || g.flush !== 1'b0) begin
        $display("FAIL seq_stall cyc=%0d got=%h exp=%h", c, g, e); bad++;
      end
      model_commit();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_priority();
    out_t e, g;
    int acks;
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 0) drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 3'd3);
      else        drive_idle();
      @(negedge clk);
      e = expect_now(); g = observed();
      acks += int'(g.ack);
      total++;
      if (g !== e) begin
        $display("FAIL priority cyc=%0d got=%h exp=%h", c, g, e); bad++;
      end
      if (c == 1) begin
        total++;
        if (g.place !== 4'b0011) begin
          $display("FAIL priority_excvec place=%b exp=0011", g.place); bad++;
        end
      end
      model_commit();
      @(posedge clk); #1;
    end
    total++;
    if (acks != 0) begin
      $display("FAIL priority_no_ack acks=%0d exp=0", acks); bad++;
    end
  endtask

  task automatic test_interrupt();
    out_t e, g;
    int acks, busy_n;
    acks = 0; busy_n = 0;
    for (int c = 0; c < DRAIN + 5; c++) begin
      if (c == 0) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 3'd5);
      else        drive_idle();
      @(negedge clk);
      e = expect_now(); g = observed();
      acks += int'(g.ack);
      busy_n += int'(g.busy);
      total++;
      if (g !== e) begin
        $display("FAIL interrupt cyc=%0d got=%h exp=%h", c, g, e); bad++;
      end
      if (c == DRAIN + 1) begin
        total++;
        if (g.place !== 4'b0101 || g.idx !== 3'd5) begin
          $display("FAIL interrupt_vec place=%b idx=%0d exp 0101/5", g.place, g.idx); bad++;
        end
      end
      model_commit();
      @(posedge clk); #1;
    end
    total++;
    if (acks != 1 || busy_n != DRAIN + 2) begin
      $display("FAIL interrupt_counts acks=%0d busy=%0d exp 1/%0d", acks, busy_n, DRAIN + 2); bad++;
    end
  endtask

  task automatic test_reset_mid();
    out_t e, g;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 3'd6);
    @(negedge clk);
    model_commit();
    @(posedge clk); #1;
    drive_idle();
    rst = 1'b1;
    #1;
    e = mk(2'd0, 4'd1, 1'b1);
    e.busy = 1'b1;
    g = observed();
    total++;
    if (g !== e) begin
      $display("FAIL reset_mid got=%h exp=%h", g, e); bad++;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      e = expect_now(); g = observed();
      total++;
      if (g !== e) begin
        $display("FAIL reset_mid_boot cyc=%0d got=%h exp=%h", c, g, e); bad++;
      end
      model_commit();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    out_t e, g;
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 3) == 0), 1'($urandom), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 14) == 0),
            2'($urandom), ($urandom_range(0, 11) == 0), 3'($urandom));
      @(negedge clk);
      e = expect_now(); g = observed();
      total++;
      if (g !== e) begin
        $display("FAIL random cyc=%0d got=%h exp=%h", c, g, e); bad++;
      end
      model_commit();
      @(posedge clk); #1;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    m_index = '0;
    m_ack   = 1'b0;
    test_reset();
    test_boot();
    test_seq_stall();
    test_priority();
    test_interrupt();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
